// File: rtl/vgen_pkg.sv
// Shared types and default 640x480 timing for the video pattern generator.
// The optional moving-bar overlay is enabled by defining VGEN_MOVING_BAR_EN.
package vgen_pkg;
    localparam int CNT_W = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_TOTAL  = 800;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_TOTAL  = 525;

    typedef enum logic [1:0] {
        PAT_BARS   = 2'd0,
        PAT_GRAD   = 2'd1,
        PAT_CHECK  = 2'd2,
        PAT_BORDER = 2'd3
    } pat_e;
endpackage

// File: rtl/vgen_if.sv
// Control inputs and registered video outputs of the pattern generator.
// master: the generator; slave: whoever drives en/pattern_sel and consumes video.
interface vgen_if #(
    parameter int CW = 8
);
    logic                       en;
    logic [1:0]                 pattern_sel;
    logic                       draw_area;
    logic                       h_sync;
    logic                       v_sync;
    logic                       sof;
    logic [vgen_pkg::CNT_W-1:0] x;
    logic [vgen_pkg::CNT_W-1:0] y;
    logic [7:0]                 frame_cnt;
    logic [CW-1:0]              red;
    logic [CW-1:0]              green;
    logic [CW-1:0]              blue;

    modport master (
        input  en, pattern_sel,
        output draw_area, h_sync, v_sync, sof, x, y, frame_cnt, red, green, blue
    );

    modport slave (
        output en, pattern_sel,
        input  draw_area, h_sync, v_sync, sof, x, y, frame_cnt, red, green, blue
    );
endinterface

// File: rtl/vgen_pattern.sv
// Combinational test-pattern colour map: (cx, cy, pattern) -> RGB.
// Blanking and overlay are applied by the parent.
module vgen_pattern
    import vgen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int CW       = 8
) (
    input  logic [CNT_W-1:0] cx_i,
    input  logic [CNT_W-1:0] cy_i,
    input  pat_e             pat_i,
    output logic [CW-1:0]    red_o,
    output logic [CW-1:0]    green_o,
    output logic [CW-1:0]    blue_o
);
    localparam logic [CNT_W-1:0] BAR_W  = CNT_W'(H_ACTIVE / 8);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);

    logic [CNT_W-1:0] bar_idx;
    logic [2:0]       bar_inv;
    logic [CW-1:0]    grad_top;
    logic             white;

    always_comb begin
        bar_idx  = cx_i / BAR_W;
        // Inverting the bar index puts white first and black last.
        bar_inv  = (bar_idx > CNT_W'(7)) ? 3'd0 : 3'd7 - bar_idx[2:0];
        grad_top = CW'({cx_i[7:0], cx_i[7:0]} >> (16 - CW));
        white    = 1'b0;
        red_o    = '0;
        green_o  = '0;
        blue_o   = '0;
        case (pat_i)
            PAT_BARS: begin
                red_o   = {CW{bar_inv[2]}};
                green_o = {CW{bar_inv[1]}};
                blue_o  = {CW{bar_inv[0]}};
            end
            PAT_GRAD: begin
                red_o   = grad_top;
                green_o = grad_top;
                blue_o  = grad_top;
            end
            PAT_CHECK:  white = cx_i[5] ^ cy_i[5];
            PAT_BORDER: white = (cx_i == '0) || (cx_i == H_LAST) ||
                                (cy_i == '0) || (cy_i == V_LAST);
            default: ;
        endcase
        if (white) begin
            red_o   = '1;
            green_o = '1;
            blue_o  = '1;
        end
    end
endmodule

// File: rtl/video_pattern_gen.sv
// Raster timing generator with selectable test patterns; all outputs registered.
// Optional moving white bar overlay when VGEN_MOVING_BAR_EN is defined.
module video_pattern_gen
    import vgen_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CW       = 8
) (
    input logic    clk,
    input logic    rst,
    vgen_if.master bus
);
    if (H_ACTIVE + H_FP + H_SYNC > H_TOTAL) begin : g_bad_h
        $error("video_pattern_gen: horizontal timing exceeds H_TOTAL");
    end
    if (V_ACTIVE + V_FP + V_SYNC > V_TOTAL) begin : g_bad_v
        $error("video_pattern_gen: vertical timing exceeds V_TOTAL");
    end
    if (H_ACTIVE < 8) begin : g_bad_ha
        $error("video_pattern_gen: H_ACTIVE must be at least 8");
    end
    if (CW < 4 || CW > 12) begin : g_bad_cw
        $error("video_pattern_gen: CW must be within 4..12");
    end

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_MAX  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic             HS_ACT = (HS_POL != 0);
    localparam logic             VS_ACT = (VS_POL != 0);

    logic [CNT_W-1:0] cx_q, cy_q, cx_d, cy_d;
    pat_e             active_pat_q, pat_cur;
    logic             at_origin;
    logic             draw_d, h_sync_d, v_sync_d;
    logic             draw_area_q, h_sync_q, v_sync_q, sof_q;
    logic [CNT_W-1:0] x_q, y_q;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [CW-1:0]    pat_r, pat_g, pat_b;
    logic [CW-1:0]    red_q, green_q, blue_q, red_d, green_d, blue_d;
    logic             force_white;

    vgen_pattern #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CW       (CW)
    ) u_pattern (
        .cx_i    (cx_q),
        .cy_i    (cy_q),
        .pat_i   (pat_cur),
        .red_o   (pat_r),
        .green_o (pat_g),
        .blue_o  (pat_b)
    );

`ifdef VGEN_MOVING_BAR_EN
    logic [CNT_W-1:0] bar_x_q, bar_x_d, bar_pos_q, bar_cur;
    logic [CNT_W:0]   bar_end;

    // bar_x_q is the next frame's position; bar_pos_q holds the one being drawn.
    always_comb begin
        bar_cur = at_origin ? bar_x_q : bar_pos_q;
        bar_end = {1'b0, bar_cur} + (CNT_W + 1)'(16);
        bar_x_d = bar_x_q;
        if (at_origin) begin
            bar_x_d = (({1'b0, bar_x_q} + (CNT_W + 1)'(4)) >= {1'b0, H_ACT}) ?
                      '0 : bar_x_q + CNT_W'(4);
        end
        force_white = draw_d && (cx_q >= bar_cur) && ({1'b0, cx_q} < bar_end);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bar_x_q   <= '0;
            bar_pos_q <= '0;
        end else if (bus.en) begin
            bar_x_q   <= bar_x_d;
            bar_pos_q <= bar_cur;
        end
    end
`else
    assign force_white = 1'b0;
`endif

    always_comb begin
        at_origin = (cx_q == '0) && (cy_q == '0);
        // The frame's pattern is taken at (0,0), so the first pixel already uses it.
        pat_cur   = at_origin ? pat_e'(bus.pattern_sel) : active_pat_q;

        cx_d = (cx_q == H_MAX) ? '0 : cx_q + CNT_W'(1);
        cy_d = cy_q;
        if (cx_q == H_MAX) begin
            cy_d = (cy_q == V_MAX) ? '0 : cy_q + CNT_W'(1);
        end

        draw_d      = (cx_q < H_ACT) && (cy_q < V_ACT);
        h_sync_d    = ((cx_q >= HS_BEG) && (cx_q < HS_END)) ? HS_ACT : ~HS_ACT;
        v_sync_d    = ((cy_q >= VS_BEG) && (cy_q < VS_END)) ? VS_ACT : ~VS_ACT;
        frame_cnt_d = at_origin ? frame_cnt_q + 8'd1 : frame_cnt_q;

        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (draw_d) begin
            red_d   = force_white ? '1 : pat_r;
            green_d = force_white ? '1 : pat_g;
            blue_d  = force_white ? '1 : pat_b;
        end
    end

    // Output stage: everything describes the counter state of the previous enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cx_q         <= '0;
            cy_q         <= '0;
            active_pat_q <= PAT_BARS;
            draw_area_q  <= 1'b0;
            h_sync_q     <= ~HS_ACT;
            v_sync_q     <= ~VS_ACT;
            sof_q        <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            frame_cnt_q  <= '0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
        end else if (bus.en) begin
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            active_pat_q <= pat_cur;
            draw_area_q  <= draw_d;
            h_sync_q     <= h_sync_d;
            v_sync_q     <= v_sync_d;
            sof_q        <= at_origin;
            x_q          <= cx_q;
            y_q          <= cy_q;
            frame_cnt_q  <= frame_cnt_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
        end
    end

    assign bus.draw_area = draw_area_q;
    assign bus.h_sync    = h_sync_q;
    assign bus.v_sync    = v_sync_q;
    assign bus.sof       = sof_q;
    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.red       = red_q;
    assign bus.green     = green_q;
    assign bus.blue      = blue_q;
endmodule
